key_debounce: RTL and testbench

//   Conditions raw push-button inputs for the flip-flop/counter lab designs on the 12 MHz board.
//   Per key: 2-flop synchronizer, then a counter-based debounce FSM.

---
 rtl/key_debounce_pkg.sv | 17 +
 rtl/key_debounce_ch.sv | 130 +++++++++++++
 rtl/key_debounce.sv | 35 +++
 tb/tb_key_debounce.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key_debounce block: the per-channel FSM state
// encoding and the debounce counter width helper.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_e;

    // Counter width for a count limit; never narrower than one bit.
    function automatic int CNT_W(input int cnt_max);
        return (cnt_max < 2) ? 1 : $clog2(cnt_max);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, polarity normalisation,
// counter-based debounce FSM with registered level and press/release pulses.
// Optional per-key toggle flop when KEY_DEBOUNCE_TOGGLE_EN is defined;
// otherwise o_toggle is tied low.
//
//   state          | meaning
//   ---------------+--------------------------------------------------
//   RELEASED       | key accepted as released, waiting for a press
//   PRESS_WAIT     | pressed seen, counting stable pressed samples
//   PRESSED        | key accepted as pressed, waiting for a release
//   RELEASE_WAIT   | released seen, counting stable released samples
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int CNT_MAX        = 240000,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_toggle
);

    localparam int            CW       = CNT_W(CNT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
    // Raw pin level that means "released"; also the synchronizer reset value.
    localparam logic          P_INV    = (KEY_ACTIVE_LOW != 0);

    logic            r_sync1;
    logic            r_sync2;
    logic            w_p;
    key_state_e      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_level;
    logic            r_press;
    logic            r_release;

    // Two-flop synchronizer for the asynchronous key pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= P_INV;
            r_sync2 <= P_INV;
        end else begin
            r_sync1 <= i_key_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_p = r_sync2 ^ P_INV;

    // Debounce FSM; level and pulses are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                ST_RELEASED: begin
                    if (w_p) begin
                        r_state <= ST_PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_p) begin
                        r_state <= ST_RELEASED;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_PRESSED;
                        r_press <= 1'b1;
                        r_level <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!w_p) begin
                        r_state <= ST_RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (w_p) begin
                        r_state <= ST_PRESSED;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= ST_RELEASED;
                        r_release <= 1'b1;
                        r_level   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RELEASED;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

`ifdef KEY_DEBOUNCE_TOGGLE_EN
    logic r_toggle;

    // T flip-flop: flips on every edge that sees the registered press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_toggle <= 1'b0;
        end else if (r_press) begin
            r_toggle <= ~r_toggle;
        end
    end

    assign o_toggle = r_toggle;
`else
    assign o_toggle = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// key_debounce top: NUM_KEYS independent debounce channels.
// Optional feature macro: KEY_DEBOUNCE_TOGGLE_EN (per-key toggle output).
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS       = 4,
    parameter int CNT_MAX        = 240000,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_toggle
);

    // One channel per key; channels share nothing but clock and reset.
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .CNT_MAX        (CNT_MAX),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_key_raw (key_raw[g]),
            .o_level   (key_level[g]),
            .o_press   (key_press[g]),
            .o_release (key_release[g]),
            .o_toggle  (key_toggle[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce (NUM_KEYS=4, CNT_MAX=4, active-low keys).
// Stimulus pushes expected pulse events; a negedge monitor pops and checks them.
module tb_key_debounce;

    localparam int NK   = 4;
    localparam int CMAX = 4;
    localparam int LAT  = CMAX + 3;   // edges from drive point to pulse-visible cycle

    typedef struct {
        int        cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lvl;
        logic [3:0] tog;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NK-1:0] raw = 4'hF;
    logic [NK-1:0] key_level, key_press, key_release, key_toggle;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [3:0] exp_lvl = 4'h0;
    logic [3:0] exp_tog = 4'h0;
    logic       tog_pending = 1'b0;
    logic [3:0] tog_want = 4'h0;
    logic [3:0] prev_lvl = 4'h0;
    logic       prev_rst = 1'b0;

    key_debounce #(
        .NUM_KEYS       (NK),
        .CNT_MAX        (CMAX),
        .KEY_ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_raw     (raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_toggle  (key_toggle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input int c, input logic [3:0] p, input logic [3:0] r);
        exp_t e;
        exp_lvl = (exp_lvl | p) & ~r;
`ifdef KEY_DEBOUNCE_TOGGLE_EN
        exp_tog = exp_tog ^ p;
`endif
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        e.lvl   = exp_lvl;
        e.tog   = exp_tog;
        sb.push_back(e);
    endtask

    // Monitor: pop on any pulse, otherwise require the level to hold.
    always @(negedge clk) begin
        exp_t e;
        if (tog_pending) begin
            chk("toggle", 32'(key_toggle), 32'(tog_want));
            tog_pending = 1'b0;
        end
        if (rst_n && ((key_press | key_release) != 4'h0)) begin
            chk("press_release_overlap", 32'(key_press & key_release), 32'h0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'(key_press | key_release), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                chk("press", 32'(key_press), 32'(e.press));
                chk("release", 32'(key_release), 32'(e.rel));
                chk("level_at_pulse", 32'(key_level), 32'(e.lvl));
                tog_pending = 1'b1;
                tog_want    = e.tog;
            end
        end else if (rst_n && prev_rst) begin
            chk("level_hold", 32'(key_level), 32'(prev_lvl));
        end
        prev_lvl = key_level;
        prev_rst = rst_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        // Reset state
        #1 rst_n = 1'b0;
        #3;
        chk("rst_level", 32'(key_level), 32'h0);
        chk("rst_press", 32'(key_press), 32'h0);
        chk("rst_release", 32'(key_release), 32'h0);
        chk("rst_toggle", 32'(key_toggle), 32'h0);
        step(2);
        rst_n = 1'b1;
        step(3);

        // 1: clean press of key 0
        step(1);
        raw = 4'b1110;
        push(cyc + LAT, 4'b0001, 4'b0000);
        step(12);

        // 2: bounce on key 1: low 2 cycles, high 1, then low held
        step(1);
        raw[1] = 1'b0;
        c = cyc;
        step(2);
        raw[1] = 1'b1;
        step(1);
        raw[1] = 1'b0;
        push(c + 3 + LAT, 4'b0010, 4'b0000);
        step(14);

        // 3: release of key 0 with a 1-cycle glitch inside RELEASE_WAIT
        step(1);
        raw[0] = 1'b1;
        c = cyc;
        step(2);
        raw[0] = 1'b0;
        step(1);
        raw[0] = 1'b1;
        push(c + 3 + LAT, 4'b0000, 4'b0001);
        step(14);
        // clean release of key 1
        step(1);
        raw[1] = 1'b1;
        push(cyc + LAT, 4'b0000, 4'b0010);
        step(12);

        // 4: simultaneous press of all keys
        step(1);
        raw = 4'b0000;
        push(cyc + LAT, 4'b1111, 4'b0000);
        step(12);
        step(1);
        raw = 4'b0001;
        push(cyc + LAT, 4'b0000, 4'b0001);
        step(12);

        // 5: reset asserted at edge 4 of a key-0 press
        step(1);
        raw = 4'b0000;
        step(5);
        rst_n = 1'b0;
        #1;
        chk("midrst_level", 32'(key_level), 32'h0);
        chk("midrst_press", 32'(key_press), 32'h0);
        chk("midrst_release", 32'(key_release), 32'h0);
        chk("midrst_toggle", 32'(key_toggle), 32'h0);
        exp_lvl = 4'h0;
        exp_tog = 4'h0;
        step(3);
        rst_n = 1'b1;
        push(cyc + LAT, 4'b1111, 4'b0000);
        step(12);

        // 6: three separated press cycles on key 2
        for (int i = 0; i < 3; i++) begin
            step(1);
            raw[2] = 1'b1;
            push(cyc + LAT, 4'b0000, 4'b0100);
            step(10);
            step(1);
            raw[2] = 1'b0;
            push(cyc + LAT, 4'b0100, 4'b0000);
            step(10);
        end

        // release everything and drain
        step(1);
        raw = 4'b1111;
        push(cyc + LAT, 4'b0000, 4'b1111);
        step(12);

        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
